// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage directly downstream of the ALU.
//
// Registers the ALU result onto the register-file write port and owns the
// architectural status register (SREG), which feeds back to the ALU flags
// input. A 16-bit multiply product is written as two single-port writes:
// R0 gets the low byte, then R1 gets the high byte on the following cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new ALU result; one accept per cycle
// MUL_HI | low product byte being written; high byte write is pending
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   in_valid/ready  handshake with the control unit (accept = both high)
//   is_mul          mul_in carries a 16-bit product to serialise
//   wr_rd_en        write alu_in to rd_addr (ignored for products)
//   rd_addr, alu_in, mul_in   destination and result data
//   flags_in/we     ALU flags, committed to SREG on accept
//   sreg_io_*       direct SREG write, independent of the handshake
//   sreg            current SREG
//   rf_wr_*         registered register-file write port
//   busy            multiply writeback in progress
module alu_writeback #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        is_mul,
  input  logic                        wr_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]       alu_in,
  input  logic [2*DATA_WIDTH-1:0]     mul_in,
  input  logic [DATA_WIDTH-1:0]       flags_in,
  input  logic                        flags_we,
  input  logic                        sreg_io_we,
  input  logic [DATA_WIDTH-1:0]       sreg_io_data,
  output logic [DATA_WIDTH-1:0]       sreg,
  output logic                        rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]       rf_wr_data,
  output logic                        busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    MUL_HI = 1'b1
  } state_t;

  state_t                      state, state_nxt;
  logic [DATA_WIDTH-1:0]       hi_byte, hi_byte_nxt;
  logic [DATA_WIDTH-1:0]       sreg_nxt;
  logic                        wr_en_nxt;
  logic [REG_ADDR_WIDTH-1:0]   wr_addr_nxt;
  logic [DATA_WIDTH-1:0]       wr_data_nxt;
  logic                        accept;

  assign in_ready = (state == IDLE) & ~reset;
  assign busy     = (state == MUL_HI);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt   = state;
    hi_byte_nxt = hi_byte;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = rf_wr_addr;
    wr_data_nxt = rf_wr_data;
    sreg_nxt    = sreg;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = REG_ADDR_WIDTH'(0);
            wr_data_nxt = mul_in[DATA_WIDTH-1:0];
            hi_byte_nxt = mul_in[2*DATA_WIDTH-1:DATA_WIDTH];
            state_nxt   = MUL_HI;
          end else if (wr_rd_en) begin
            // Address/data only move on a real write so the port holds its
            // last values otherwise and a don't-care alu_in never lands here.
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = rd_addr;
            wr_data_nxt = alu_in;
          end
        end
      end
      MUL_HI: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = REG_ADDR_WIDTH'(1);
        wr_data_nxt = hi_byte;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Direct SREG write is applied last so it wins over committed flags.
    if (accept && flags_we) sreg_nxt = flags_in;
    if (sreg_io_we)         sreg_nxt = sreg_io_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hi_byte    <= '0;
      sreg       <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      state      <= state_nxt;
      hi_byte    <= hi_byte_nxt;
      sreg       <= sreg_nxt;
      rf_wr_en   <= wr_en_nxt;
      rf_wr_addr <= wr_addr_nxt;
      rf_wr_data <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed test-plan steps followed by random traffic,
// checked against a queue-based reference model of the writeback stage.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        is_mul;
  logic        wr_rd_en;
  logic [4:0]  rd_addr;
  logic [7:0]  alu_in;
  logic [15:0] mul_in;
  logic [7:0]  flags_in;
  logic        flags_we;
  logic        sreg_io_we;
  logic [7:0]  sreg_io_data;
  logic [7:0]  sreg;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [7:0]  rf_wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  // Writes still owed by the stage after the current edge, plus model SREG.
  wr_t        pend[$];
  logic [7:0] m_sreg = 8'h00;
  int         write_count = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_mul       (is_mul),
    .wr_rd_en     (wr_rd_en),
    .rd_addr      (rd_addr),
    .alu_in       (alu_in),
    .mul_in       (mul_in),
    .flags_in     (flags_in),
    .flags_we     (flags_we),
    .sreg_io_we   (sreg_io_we),
    .sreg_io_data (sreg_io_data),
    .sreg         (sreg),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic w, input logic [4:0] rd,
                       input logic [7:0] alu, input logic [15:0] mul, input logic [7:0] fl,
                       input logic fwe, input logic iowe, input logic [7:0] iod);
    in_valid = v; is_mul = m; wr_rd_en = w; rd_addr = rd; alu_in = alu; mul_in = mul;
    flags_in = fl; flags_we = fwe; sreg_io_we = iowe; sreg_io_data = iod;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Advance one clock: predict from the currently driven inputs, then
  // sample the DUT 1 time unit after the edge and compare.
  task automatic step();
    logic       m_en;
    wr_t        w;
    bit         acc;
    m_en = 1'b0;
    w.a  = '0;
    w.d  = '0;
    if (reset) begin
      pend.delete();
      m_sreg = 8'h00;
    end else begin
      acc = (pend.size() == 0) && in_valid;
      if (pend.size() != 0) begin
        w = pend.pop_front();
        m_en = 1'b1;
      end else if (acc) begin
        if (is_mul) begin
          w.a = 5'd0; w.d = mul_in[7:0]; m_en = 1'b1;
          pend.push_back('{a: 5'd1, d: mul_in[15:8]});
        end else if (wr_rd_en) begin
          w.a = rd_addr; w.d = alu_in; m_en = 1'b1;
        end
      end
      if (acc && flags_we) m_sreg = flags_in;
      if (sreg_io_we)      m_sreg = sreg_io_data;
    end
    @(posedge clk);
    #1;
    if (m_en) write_count++;
    chk("rf_wr_en", 32'(rf_wr_en), 32'(m_en));
    chk("sreg", 32'(sreg), 32'(m_sreg));
    chk("in_ready", 32'(in_ready), 32'((pend.size() == 0) && !reset));
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    if (m_en) begin
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(w.a));
      chk("rf_wr_data", 32'(rf_wr_data), 32'(w.d));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_sreg", 32'(sreg), 32'h0);
    chk("reset_addr", 32'(rf_wr_addr), 32'h0);
    chk("reset_data", 32'(rf_wr_data), 32'h0);

    // ADD result with flags commit.
    drive(1'b1, 1'b0, 1'b1, 5'd18, 8'h3C, 16'h0000, 8'h01, 1'b1, 1'b0, 8'h00);
    step();
    idle_inputs();
    chk("add_addr", 32'(rf_wr_addr), 32'd18);
    chk("add_data", 32'(rf_wr_data), 32'h3C);
    chk("add_sreg", 32'(sreg), 32'h01);
    step();
    chk("add_en_drop", 32'(rf_wr_en), 32'd0);

    // Multiply: low byte to R0, then high byte to R1.
    drive(1'b1, 1'b1, 1'b0, 5'd7, 8'h00, 16'hA5C3, 8'h01, 1'b1, 1'b0, 8'h00);
    step();
    idle_inputs();
    chk("mul_lo_data", 32'(rf_wr_data), 32'hC3);
    chk("mul_lo_ready", 32'(in_ready), 32'd0);
    step();
    chk("mul_hi_addr", 32'(rf_wr_addr), 32'd1);
    chk("mul_hi_data", 32'(rf_wr_data), 32'hA5);
    chk("mul_hi_ready", 32'(in_ready), 32'd1);
    step();

    // Back-to-back non-mul ops.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 5'(16 + i), 8'(8'h10 + i), 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      chk("b2b_ready", 32'(in_ready), 32'd1);
      chk("b2b_addr", 32'(rf_wr_addr), 32'(16 + i));
    end
    idle_inputs();
    step();

    // Flags commit colliding with direct SREG write.
    drive(1'b1, 1'b0, 1'b1, 5'd3, 8'h77, 16'h0000, 8'h02, 1'b1, 1'b1, 8'h80);
    step();
    idle_inputs();
    chk("collision_sreg", 32'(sreg), 32'h80);
    step();

    // Stall: in_valid held across MUL_HI, single write of 8'h55.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 16'h0F0E, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    write_count = 0;
    drive(1'b1, 1'b0, 1'b1, 5'd20, 8'h55, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    chk("stall_hi_data", 32'(rf_wr_data), 32'h0F);
    step();
    chk("stall_addr", 32'(rf_wr_addr), 32'd20);
    chk("stall_data", 32'(rf_wr_data), 32'h55);
    idle_inputs();
    step();
    step();
    chk("stall_write_count", 32'(write_count), 32'd2);

    // Reset during MUL_HI drops the high-byte write.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 16'h1234, 8'h01, 1'b1, 1'b0, 8'h00);
    step();
    idle_inputs();
    reset = 1'b1;
    sreg_io_we = 1'b1;
    sreg_io_data = 8'hFF;
    step();
    chk("rst_mul_en", 32'(rf_wr_en), 32'd0);
    chk("rst_mul_sreg", 32'(sreg), 32'h00);
    reset = 1'b0;
    idle_inputs();
    step();
    chk("rst_mul_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_busy", 32'(busy), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            5'($urandom), 8'($urandom), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0), 8'($urandom));
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
